// File: rtl/b02_seq_ctrl_pkg.sv
// Shared types and defaults for the b02 sequencing controller.
// Optional word counter output is enabled with B02_SEQ_CTRL_WCNT_EN.
package b02_seq_pkg;

    localparam int WORD_W_DEF    = 8;
    localparam int CNT_W_DEF     = 4;
    localparam int DRAIN_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        RESULT
    } seq_state_e;

    // Index width for counting n items; never returns less than 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/b02_seq_ctrl_if.sv
// Word-in / result-out valid-ready handshakes of the b02 sequencing controller.
// The slave modport is the controller side, the master modport its environment.
interface b02_seq_ctrl_if
    import b02_seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;

    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_hit
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_hit
    );

endinterface

// File: rtl/b02_seq_ctrl_piso.sv
// Parallel-load, MSB-first shift register feeding the recognizer line.
// last_o flags that serial_o currently presents the final bit of the word.
module b02_seq_piso
    import b02_seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clock,
    input  logic              nRESET_G,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              shift_en,
    output logic              serial_o,
    output logic              last_o
);

    localparam int IDX_W = clog2(WORD_W);

    logic [WORD_W-1:0] sreg;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clock) begin
        if (!nRESET_G) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= load_word;
            idx  <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[WORD_W-2:0], 1'b0};
            idx  <= idx + 1'b1;
        end
    end

    assign serial_o = sreg[WORD_W-1];
    assign last_o   = (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/b02_seq_ctrl.sv
// Sequencing controller: clears the b02 recognizer, shifts a word onto its line,
// counts U_REG pulses and returns one result per word. Define B02_SEQ_CTRL_WCNT_EN for word_cnt_o.
module b02_seq_ctrl
    import b02_seq_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic          clock,
    input  logic          nRESET_G,
    b02_seq_ctrl_if.slave bus,
    output logic          linea_o,
    output logic          rec_nreset_o,
    input  logic          u_reg_i,
    output logic          busy
`ifdef B02_SEQ_CTRL_WCNT_EN
    ,
    output logic [15:0]   word_cnt_o
`endif
);

    localparam int               DRAIN_W = clog2(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_e         state;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic               hit_q;
    logic               tail_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               piso_load;
    logic               piso_shift;
    logic               piso_serial;
    logic               piso_last;
    logic               accept;

    assign accept     = bus.in_valid && bus.in_ready;
    assign piso_load  = accept;
    assign piso_shift = (state == CLR) || ((state == SHIFT) && !tail_q);

    b02_seq_piso #(
        .WORD_W(WORD_W)
    ) u_piso (
        .clock    (clock),
        .nRESET_G (nRESET_G),
        .load     (piso_load),
        .load_word(bus.in_word),
        .shift_en (piso_shift),
        .serial_o (piso_serial),
        .last_o   (piso_last)
    );

    // Detections are only counted while the line is being driven or drained.
    always_comb begin
        cnt_next = cnt_q;
        if (((state == SHIFT) || (state == DRAIN)) && u_reg_i && (cnt_q != CNT_MAX)) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    // linea_o is loaded one edge ahead from the shifter; tail_q marks that the last bit is on the line.
    always_ff @(posedge clock) begin
        if (!nRESET_G) begin
            state     <= IDLE;
            linea_o   <= 1'b0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            tail_q    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            cnt_q <= cnt_next;
            hit_q <= (cnt_next != '0);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= CLR;
                        cnt_q   <= '0;
                        hit_q   <= 1'b0;
                        linea_o <= 1'b0;
                        tail_q  <= 1'b0;
                    end
                end
                CLR: begin
                    state   <= SHIFT;
                    linea_o <= piso_serial;
                    tail_q  <= piso_last;
                end
                SHIFT: begin
                    if (tail_q) begin
                        state     <= DRAIN;
                        linea_o   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        linea_o <= piso_serial;
                        tail_q  <= piso_last;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state <= RESULT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = nRESET_G && (state == IDLE);
    assign bus.out_valid = (state == RESULT);
    assign bus.out_count = cnt_q;
    assign bus.out_hit   = hit_q;
    assign busy          = (state != IDLE);
    assign rec_nreset_o  = nRESET_G && (state != CLR);

`ifdef B02_SEQ_CTRL_WCNT_EN
    // Completed result transfers since reset, wrapping at 16 bits.
    always_ff @(posedge clock) begin
        if (!nRESET_G) begin
            word_cnt_o <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            word_cnt_o <= word_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_b02_seq_ctrl.sv
// Self-checking bench for b02_seq_ctrl: directed scenarios plus 200 random words
// compared against a bit-list / popcount reference model.
module tb_b02_seq_ctrl;
    import b02_seq_pkg::*;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int C2 = 2;
    localparam int LAT = 1 + W + D;
    localparam int PERIOD = 3 + W + D;

    logic clock = 1'b0;
    logic nRESET_G;
    logic linea_o, rec_nreset_o, u_reg_i, busy;
    logic linea2, rec2, u2, busy2;
`ifdef B02_SEQ_CTRL_WCNT_EN
    logic [15:0] word_cnt_o;
    logic [15:0] word_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    b02_seq_ctrl_if #(.WORD_W(W), .CNT_W(C))  bus ();
    b02_seq_ctrl_if #(.WORD_W(W), .CNT_W(C2)) bus2 ();

    b02_seq_ctrl #(.WORD_W(W), .CNT_W(C), .DRAIN_CYC(D)) dut (
        .clock       (clock),
        .nRESET_G    (nRESET_G),
        .bus         (bus),
        .linea_o     (linea_o),
        .rec_nreset_o(rec_nreset_o),
        .u_reg_i     (u_reg_i),
        .busy        (busy)
`ifdef B02_SEQ_CTRL_WCNT_EN
        ,
        .word_cnt_o  (word_cnt_o)
`endif
    );

    b02_seq_ctrl #(.WORD_W(W), .CNT_W(C2), .DRAIN_CYC(D)) dut2 (
        .clock       (clock),
        .nRESET_G    (nRESET_G),
        .bus         (bus2),
        .linea_o     (linea2),
        .rec_nreset_o(rec2),
        .u_reg_i     (u2),
        .busy        (busy2)
`ifdef B02_SEQ_CTRL_WCNT_EN
        ,
        .word_cnt_o  (word_cnt2)
`endif
    );

    always #5 clock = ~clock;

    // Reference: detections are the 1s of upat (one per counted cycle), saturated at the counter max.
    function automatic int model_count(input logic [W+D-1:0] upat, input int cw);
        int s;
        int mx;
        s = 0;
        for (int i = 0; i < W + D; i++) s += int'(upat[i]);
        mx = (1 << cw) - 1;
        return (s > mx) ? mx : s;
    endfunction

    // Offers one word, plays upat on u_reg_i during the counted cycles, returns observations at out_valid.
    task automatic drive_word(input logic [W-1:0] w, input logic [W+D-1:0] upat, input bit noise,
                              output int lat, output logic [W-1:0] lseq,
                              output logic [C-1:0] cnt, output logic hit, output logic [15:0] recmask);
        int n;
        lat = -1;
        lseq = '0;
        recmask = '0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            bus.in_valid = 1'b0;
            lat = -2;
            cnt = '0;
            hit = 1'b0;
            return;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_word  = W'($urandom);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0 && bus.out_valid) begin
                lat = cyc;
                break;
            end
            if (cyc < 16) recmask[cyc] = ~rec_nreset_o;
            if (cyc >= 1 && cyc <= W) lseq[W-cyc] = linea_o;
            if (cyc >= 1 && cyc <= W + D) u_reg_i = upat[cyc-1];
            else u_reg_i = noise ? 1'($urandom) : 1'b0;
            @(negedge clock);
        end
        cnt = bus.out_count;
        hit = bus.out_hit;
        u_reg_i = noise ? 1'($urandom) : 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRESET_G = 1'b0;
        #1;
        checks++; if (rec_nreset_o !== 1'b0) begin errors++; $display("FAIL reset_rec_n: got %b want 0", rec_nreset_o); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        repeat (3) @(negedge clock);
        checks++; if (linea_o !== 1'b0) begin errors++; $display("FAIL reset_linea: got %b want 0", linea_o); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
        checks++; if (bus.out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit: got %b want 0", bus.out_hit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef B02_SEQ_CTRL_WCNT_EN
        checks++; if (word_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt_o); end
`endif
        nRESET_G = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (rec_nreset_o !== 1'b1) begin errors++; $display("FAIL release_rec_n: got %b want 1", rec_nreset_o); end
    endtask

    task automatic test_basic();
        int lat;
        logic [W-1:0] lseq;
        logic [C-1:0] cnt;
        logic hit;
        logic [15:0] rm;
        drive_word(8'hA5, '0, 1'b0, lat, lseq, cnt, hit, rm);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++; if (lseq !== 8'hA5) begin errors++; $display("FAIL basic_linea_seq: got %h want a5", lseq); end
        checks++; if (rm !== 16'h0001) begin errors++; $display("FAIL basic_rec_clear: got %h want 0001", rm); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL basic_count: got %0d want 0", cnt); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL basic_hit: got %b want 0", hit); end
        take_result();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got ready=%b busy=%b want 1,0", bus.in_ready, busy); end
    endtask

    task automatic test_count3();
        int lat;
        logic [W-1:0] lseq;
        logic [C-1:0] cnt;
        logic hit;
        logic [15:0] rm;
        drive_word(8'h3C, 10'b00_0001_1100, 1'b1, lat, lseq, cnt, hit, rm);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL count3_latency: got %0d want %0d", lat, LAT); end
        checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL count3_count: got %0d want 3", cnt); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL count3_hit: got %b want 1", hit); end
        take_result();
    endtask

    task automatic test_saturate();
        bit seen;
        @(negedge clock);
        checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready: got %b want 1", bus2.in_ready); end
        bus2.in_valid = 1'b1;
        bus2.in_word  = W'($urandom);
        @(negedge clock);
        bus2.in_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0 && bus2.out_valid) begin
                seen = 1'b1;
                break;
            end
            u2 = (cyc >= 1 && cyc <= 6);
            @(negedge clock);
        end
        u2 = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sat_timeout: got no out_valid want out_valid"); end
        checks++; if (bus2.out_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", bus2.out_count); end
        checks++; if (bus2.out_hit !== 1'b1) begin errors++; $display("FAIL sat_hit: got %b want 1", bus2.out_hit); end
        bus2.out_ready = 1'b1;
        @(negedge clock);
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] lseq;
        logic [C-1:0] cnt;
        logic hit;
        logic [15:0] rm;
        logic [W+D-1:0] upat;
        int exp_c;
        upat = (W+D)'($urandom);
        exp_c = model_count(upat, C);
        drive_word(W'($urandom), upat, 1'b1, lat, lseq, cnt, hit, rm);
        checks++; if (int'(cnt) !== exp_c) begin errors++; $display("FAIL bp_count: got %0d want %0d", cnt, exp_c); end
        for (int i = 0; i < 20; i++) begin
            u_reg_i = 1'($urandom);
            @(negedge clock);
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_count) !== exp_c || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got valid=%b count=%0d ready=%b want 1,%0d,0", i, bus.out_valid, bus.out_count, bus.in_ready, exp_c);
            end
        end
        u_reg_i = 1'b0;
        take_result();
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b want 0,0", bus.out_valid, busy); end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        bit seen;
        int lat;
        logic [W-1:0] lseq;
        logic [C-1:0] cnt;
        logic hit;
        logic [15:0] rm;
        w = W'($urandom);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (linea_o !== w[W-5]) begin errors++; $display("FAIL mid_bit4: got %b want %b", linea_o, w[W-5]); end
        nRESET_G = 1'b0;
        #1;
        checks++; if (rec_nreset_o !== 1'b0) begin errors++; $display("FAIL mid_rec_comb: got %b want 0", rec_nreset_o); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || linea_o !== 1'b0 || rec_nreset_o !== 1'b0) begin errors++; $display("FAIL mid_abort: got busy=%b linea=%b rec_n=%b want 0,0,0", busy, linea_o, rec_nreset_o); end
        nRESET_G = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_result: got out_valid want none"); end
        drive_word(8'h5A, 10'b11_0000_0001, 1'b0, lat, lseq, cnt, hit, rm);
        checks++; if (lat !== LAT || lseq !== 8'h5A || cnt !== 4'd3) begin errors++; $display("FAIL mid_recover: got lat=%0d seq=%h cnt=%0d want %0d,5a,3", lat, lseq, cnt, LAT); end
        take_result();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int n;
        first = -1;
        second = -1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_word  = W'($urandom);
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (first < 0 || second - first !== PERIOD) begin errors++; $display("FAIL b2b_period: got %0d want %0d", second - first, PERIOD); end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        int exp_c;
        int nwords;
        logic [W-1:0] w;
        logic [W-1:0] lseq;
        logic [W+D-1:0] upat;
        logic [C-1:0] cnt;
        logic hit;
        logic [15:0] rm;
        @(negedge clock);
        nRESET_G = 1'b0;
        @(negedge clock);
        nRESET_G = 1'b1;
        nwords = 0;
        for (int k = 0; k < 200; k++) begin
            w = W'($urandom);
            upat = (W+D)'($urandom);
            exp_c = model_count(upat, C);
            drive_word(w, upat, 1'b1, lat, lseq, cnt, hit, rm);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd_latency: word %0d got %0d want %0d", k, lat, LAT); end
            checks++; if (lseq !== w) begin errors++; $display("FAIL rnd_linea_seq: word %0d got %h want %h", k, lseq, w); end
            checks++; if (int'(cnt) !== exp_c) begin errors++; $display("FAIL rnd_count: word %0d got %0d want %0d", k, cnt, exp_c); end
            checks++; if (hit !== (exp_c != 0)) begin errors++; $display("FAIL rnd_hit: word %0d got %b want %b", k, hit, exp_c != 0); end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            take_result();
            nwords++;
        end
        u_reg_i = 1'b0;
`ifdef B02_SEQ_CTRL_WCNT_EN
        checks++; if (word_cnt_o !== 16'(nwords)) begin errors++; $display("FAIL rnd_word_cnt: got %0d want %0d", word_cnt_o, nwords); end
`endif
    endtask

    initial begin
        nRESET_G = 1'b0;
        u_reg_i = 1'b0;
        u2 = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_word = '0;
        bus2.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_count3();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/b02_seq_ctrl.md
# b02_seq_ctrl

Sequencing controller for the b02 serial-line recognizer. It accepts parallel words over a valid/ready handshake and clears the recognizer before each word. It then serializes the word MSB-first onto the recognizer's line input and counts the recognizer's output pulses. When the word is done it returns one result record per word over a second valid/ready handshake.

## Interface
- WORD_W, 8, bits per word shifted onto the line (≥2)
- CNT_W, 4, width of the per-word detection counter
- DRAIN_CYC, 2, cycles the line is held at 0 after the last bit, covering recognizer output latency (≥1)

- clock  in  1  single clock, rising edge
- nRESET_G  in  1  synchronous, active-low reset
- in_valid  in  1  word available
- in_ready  out  1  controller can accept a word
- in_word  in  WORD_W  word to serialize
- linea_o  out  1  serial bit to recognizer LINEA
- rec_nreset_o  out  1  active-low synchronous clear to recognizer nRESET_G
- u_reg_i  in  1  recognizer U_REG
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_count  out  CNT_W  U_REG-high cycles seen for this word, saturating
- out_hit  out  1  out_count != 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CLR, SHIFT, DRAIN, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_word, clear the counter, go to CLR.
- CLR: one cycle. rec_nreset_o=0, linea_o=0. Go to SHIFT with bit index k=0.
- SHIFT: WORD_W cycles.
  - linea_o = latched word[WORD_W-1-k].
  - After k=WORD_W-1, go to DRAIN.
- DRAIN:
  - DRAIN_CYC cycles, linea_o=0.
  - Then go to RESULT.
- Counting:
  - The counter increments on every cycle with u_reg_i=1 while in SHIFT or DRAIN.
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - u_reg_i is ignored in IDLE, CLR and RESULT.
- RESULT:
  - out_valid=1; out_count and out_hit stay stable until accepted.
  - On out_ready: go to IDLE.
- in_ready=0 in every state except IDLE. A new word is never accepted in the cycle a result is accepted, so there is one IDLE cycle minimum between words.
- rec_nreset_o = nRESET_G && state!=CLR (combinational). The recognizer is therefore held in reset while the controller is in reset.

## Timing
- Reset values:
  - state IDLE.
  - linea_o=0, out_valid=0, out_count=0, out_hit=0, busy=0.
  - rec_nreset_o=0 while nRESET_G=0.
  - in_ready=0 while nRESET_G=0, and 1 in the first cycle after release.
- linea_o, out_count and out_hit are registered. in_ready, out_valid and busy decode the state register.
- Latency from the accept edge to out_valid high is 1+WORD_W+DRAIN_CYC cycles: 11 at defaults.
- Throughput is one word per 3+WORD_W+DRAIN_CYC cycles with out_ready tied high.
- Reset asserted mid-operation (any state): on the next edge, state returns to IDLE, the in-flight word is discarded and no result is produced.
- out_valid held with out_ready=0 blocks indefinitely, with no data change.

## Configuration
- B02_SEQ_CTRL_WCNT_EN defined:
  - Adds output word_cnt_o [15:0], reset to 0.
  - It increments on each out_valid&&out_ready and wraps 0xFFFF→0.
- Not defined: the port and counter do not exist.
- Core behaviour is identical either way.

## Structure
- Package b02_seq_pkg holds:
  - the state enum (IDLE, CLR, SHIFT, DRAIN, RESULT);
  - default constants for WORD_W, CNT_W and DRAIN_CYC;
  - the bit-index width function clog2(WORD_W).
- One sub-module, b02_seq_piso: a WORD_W-bit parallel-load, MSB-first shift register.
  - Inputs: load, shift_en.
  - Outputs: serial_o, last_o.
  - The FSM and the saturating counter stay in the top level.

## Test plan
- Reset release, then in_word=8'hA5 with u_reg_i stubbed low:
  - rec_nreset_o low exactly one cycle after accept;
  - linea_o sequence 1,0,1,0,0,1,0,1;
  - out_valid 11 cycles after accept, out_count=0, out_hit=0.
- Stub drives u_reg_i=1 for 3 cycles during SHIFT → out_count=3, out_hit=1.
- CNT_W=2, u_reg_i=1 for 6 cycles → out_count=3 (saturated).
- Hold out_ready=0 for 20 cycles in RESULT:
  - out_valid and out_count stay stable and in_ready stays 0;
  - on release, one transfer, then IDLE.
- Assert nRESET_G=0 during SHIFT bit 4:
  - next cycle state IDLE, linea_o=0, rec_nreset_o=0;
  - no out_valid until a new word completes.
- Integrate with a b02 instance plus a behavioural model:
  - random 200 words, with and without B02_SEQ_CTRL_WCNT_EN;
  - out_count matches the model each word;
  - word_cnt_o=200 at end.
